// File: rtl/adam_apb_init_pkg.sv
// ============================================================================
// adam_apb_init_pkg : shared types and constants for adam_apb_initiator
// Revision: 1.0
// ============================================================================
`default_nettype none

package adam_apb_init_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam logic RESP_OKAY   = 1'b0;
  localparam logic RESP_SLVERR = 1'b1;

  localparam logic [2:0] PPROT_DEFAULT = 3'b000;

endpackage

`default_nettype wire

// File: rtl/adam_apb_initiator.sv
// ============================================================================
// adam_apb_initiator : valid/ready request -> single APB4 transfer -> response
// Optional ACCESS-phase timeout enabled by ADAM_APB_INIT_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module adam_apb_initiator
  import adam_apb_init_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pause_req,
  output logic                  pause_ack,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_write,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [STRB_WIDTH-1:0] req_strb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [2:0]            pprot,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [DATA_WIDTH-1:0] pwdata,
  output logic [STRB_WIDTH-1:0] pstrb,
  input  logic                  pready,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pslverr
);

  if (((DATA_WIDTH % 8) != 0) || (TIMEOUT_CYCLES < 1)) begin : g_bad_params
    $error("adam_apb_initiator: DATA_WIDTH must be a multiple of 8 and TIMEOUT_CYCLES >= 1");
  end

  state_e state;
  logic   tmo_hit;

  // Gated by rst_n so no request can be taken while reset is held.
  assign req_ready = rst_n && (state == IDLE) && !pause_req && !pause_ack;
  assign pprot     = PPROT_DEFAULT;

`ifdef ADAM_APB_INIT_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

  logic [TMO_W-1:0] tmo_cnt;
  logic [TMO_W-1:0] tmo_next;

  assign tmo_next = tmo_cnt + 1'b1;
  assign tmo_hit  = (state == ACCESS) && !pready && (tmo_next == TMO_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state == SETUP) begin
      tmo_cnt <= '0;
    end else if ((state == ACCESS) && !pready) begin
      tmo_cnt <= tmo_next;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      pstrb     <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= RESP_OKAY;
      rsp_rdata <= '0;
      pause_ack <= 1'b0;
    end else begin
      // Parking only happens from IDLE, so in-flight work always drains first.
      pause_ack <= (state == IDLE) && pause_req;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            state   <= SETUP;
            psel    <= 1'b1;
            penable <= 1'b0;
            paddr   <= req_addr;
            pwrite  <= req_write;
            pwdata  <= req_wdata;
            pstrb   <= req_write ? req_strb : '0;
          end
        end
        SETUP: begin
          state   <= ACCESS;
          penable <= 1'b1;
        end
        ACCESS: begin
          if (pready) begin
            state     <= RESP;
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= pslverr ? RESP_SLVERR : RESP_OKAY;
            rsp_rdata <= pwrite ? '0 : prdata;
          end else if (tmo_hit) begin
            state     <= RESP;
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= RESP_SLVERR;
            rsp_rdata <= '0;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_adam_apb_initiator.sv
// ============================================================================
// tb_adam_apb_initiator : directed self-checking bench for adam_apb_initiator
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_adam_apb_initiator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pause_req, pause_ack;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        req_write;
  logic [31:0] req_wdata;
  logic [3:0]  req_strb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] paddr;
  logic [2:0]  pprot;
  logic        psel, penable, pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  adam_apb_initiator #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pause_req(pause_req), .pause_ack(pause_ack),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .paddr(paddr), .pprot(pprot), .psel(psel),
    .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  // Simple APB slave: fixed wait states, optional error, 16-word memory.
  int          wait_states = 0;
  bit          slv_err = 0;
  int          wcnt = 0;
  logic [31:0] mem [16];

  assign pready  = psel && penable && (wcnt == wait_states);
  assign prdata  = pready ? mem[paddr[5:2]] : 32'hDEAD_BEEF;
  assign pslverr = slv_err && pready;

  always @(posedge clk) begin
    if (psel && penable && !pready) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (psel && penable && pready && pwrite && !slv_err) mem[paddr[5:2]] <= pwdata;
  end

  task automatic run_xfer(input logic [31:0] a, input logic w, input logic [31:0] wd,
                          input logic [3:0] st, output int lat, output logic [31:0] rd,
                          output logic er, output bit ok_apb);
    int cyc;
    ok_apb = 1; lat = -1; rd = 'x; er = 'x;
    @(negedge clk);
    req_addr = a; req_write = w; req_wdata = wd; req_strb = st; req_valid = 1;
    cyc = 0;
    while (!req_ready && cyc < 50) begin @(negedge clk); cyc++; end
    if (!req_ready) begin req_valid = 0; lat = -2; return; end
    @(negedge clk);
    req_valid = 0;
    for (int c = 1; c <= 60; c++) begin
      if (rsp_valid) begin lat = c; break; end
      if (c == 1 && !(psel && !penable)) ok_apb = 0;
      if (c >= 2 && !(psel && penable)) ok_apb = 0;
      if (paddr !== a || pwrite !== w || pstrb !== (w ? st : 4'h0) || (w && pwdata !== wd)) ok_apb = 0;
      @(negedge clk);
    end
    rd = rsp_rdata; er = rsp_err;
    if (lat > 0) begin
      rsp_ready = 1;
      @(negedge clk);
      rsp_ready = 0;
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    #1;
    tests++;
    if (req_ready !== 1'b0) begin fails++; $display("FAIL reset_req_ready got %b exp 0", req_ready); end
    tests++;
    if ({psel, penable, pwrite, rsp_valid, rsp_err, pause_ack} !== 6'b0) begin
      fails++; $display("FAIL reset_ctrl got %b exp 000000", {psel, penable, pwrite, rsp_valid, rsp_err, pause_ack});
    end
    tests++;
    if ({paddr, pwdata, pstrb, rsp_rdata, pprot} !== '0) begin
      fails++; $display("FAIL reset_data paddr=%h pwdata=%h pstrb=%h rdata=%h pprot=%h exp all 0", paddr, pwdata, pstrb, rsp_rdata, pprot);
    end
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b1) begin fails++; $display("FAIL idle_req_ready got %b exp 1", req_ready); end
  endtask

  task automatic test_write();
    int lat; logic [31:0] rd; logic er; bit ok;
    wait_states = 0; slv_err = 0;
    run_xfer(32'h04, 1'b1, 32'hA5A5_1234, 4'hF, lat, rd, er, ok);
    tests++;
    if (lat !== 3) begin fails++; $display("FAIL write_latency got %0d exp 3", lat); end
    tests++;
    if (!ok) begin fails++; $display("FAIL write_apb_phases got %0d exp 1", ok); end
    tests++;
    if (er !== 1'b0 || rd !== 32'h0) begin fails++; $display("FAIL write_rsp got err=%b rdata=%h exp err=0 rdata=0", er, rd); end
    tests++;
    if (rsp_valid !== 1'b0 || psel !== 1'b0) begin
      fails++; $display("FAIL write_after_hs got rsp_valid=%b psel=%b exp 0 0", rsp_valid, psel);
    end
  endtask

  task automatic test_read_wait();
    int lat; logic [31:0] rd; logic er; bit ok;
    wait_states = 4; slv_err = 0;
    run_xfer(32'h18, 1'b0, 32'h0, 4'hF, lat, rd, er, ok);
    tests++;
    if (lat !== 7) begin fails++; $display("FAIL read_latency got %0d exp 7", lat); end
    tests++;
    if (rd !== 32'h0000_00FF || er !== 1'b0) begin fails++; $display("FAIL read_rsp got rdata=%h err=%b exp 000000ff 0", rd, er); end
    tests++;
    if (!ok) begin fails++; $display("FAIL read_apb_phases got %0d exp 1", ok); end
  endtask

  task automatic test_slverr();
    int lat; logic [31:0] rd; logic er; bit ok;
    wait_states = 0; slv_err = 1;
    run_xfer(32'h00, 1'b1, 32'h1111_2222, 4'h3, lat, rd, er, ok);
    tests++;
    if (er !== 1'b1 || rd !== 32'h0 || lat !== 3) begin
      fails++; $display("FAIL slverr_rsp got err=%b rdata=%h lat=%0d exp 1 0 3", er, rd, lat);
    end
    slv_err = 0;
    run_xfer(32'h04, 1'b0, 32'h0, 4'h0, lat, rd, er, ok);
    tests++;
    if (er !== 1'b0 || rd !== 32'hA5A5_1234) begin
      fails++; $display("FAIL readback_rsp got err=%b rdata=%h exp 0 a5a51234", er, rd);
    end
  endtask

  task automatic test_pause_priority();
    @(negedge clk);
    pause_req = 1; req_valid = 1; req_addr = 32'h08; req_write = 0;
    #1;
    tests++;
    if (req_ready !== 1'b0) begin fails++; $display("FAIL pause_wins_ready got %b exp 0", req_ready); end
    @(negedge clk);
    tests++;
    if (pause_ack !== 1'b1 || psel !== 1'b0) begin
      fails++; $display("FAIL pause_wins_ack got ack=%b psel=%b exp 1 0", pause_ack, psel);
    end
    pause_req = 0; req_valid = 0;
    @(negedge clk);
    tests++;
    if (pause_ack !== 1'b0) begin fails++; $display("FAIL pause_release_ack got %b exp 0", pause_ack); end
  endtask

  task automatic test_pause_drain();
    int cyc;
    wait_states = 3; slv_err = 0;
    @(negedge clk);
    req_addr = 32'h18; req_write = 0; req_wdata = 0; req_strb = 0; req_valid = 1;
    @(negedge clk);
    req_valid = 0;
    cyc = 0;
    while (!(psel && penable) && cyc < 20) begin @(negedge clk); cyc++; end
    pause_req = 1;
    req_valid = 1; req_addr = 32'h04;
    cyc = 0;
    while (!rsp_valid && cyc < 20) begin @(negedge clk); cyc++; end
    tests++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hFF || rsp_err !== 1'b0) begin
      fails++; $display("FAIL pause_drain_rsp got valid=%b rdata=%h err=%b exp 1 ff 0", rsp_valid, rsp_rdata, rsp_err);
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    tests++;
    if (pause_ack !== 1'b0 || req_ready !== 1'b0) begin
      fails++; $display("FAIL pause_idle_first got ack=%b ready=%b exp 0 0", pause_ack, req_ready);
    end
    repeat (2) begin
      @(negedge clk);
      tests++;
      if (pause_ack !== 1'b1 || req_ready !== 1'b0 || psel !== 1'b0) begin
        fails++; $display("FAIL pause_parked got ack=%b ready=%b psel=%b exp 1 0 0", pause_ack, req_ready, psel);
      end
    end
    pause_req = 0;
    #1;
    tests++;
    if (req_ready !== 1'b0 || pause_ack !== 1'b1) begin
      fails++; $display("FAIL unpause_same_cycle got ready=%b ack=%b exp 0 1", req_ready, pause_ack);
    end
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b1 || pause_ack !== 1'b0) begin
      fails++; $display("FAIL unpause_next_cycle got ready=%b ack=%b exp 1 0", req_ready, pause_ack);
    end
    @(negedge clk);
    req_valid = 0;
    tests++;
    if (psel !== 1'b1 || penable !== 1'b0 || paddr !== 32'h04) begin
      fails++; $display("FAIL unpause_setup got psel=%b penable=%b paddr=%h exp 1 0 4", psel, penable, paddr);
    end
    cyc = 0;
    while (!rsp_valid && cyc < 20) begin @(negedge clk); cyc++; end
    tests++;
    if (rsp_rdata !== 32'hA5A5_1234 || rsp_valid !== 1'b1) begin
      fails++; $display("FAIL unpause_read got valid=%b rdata=%h exp 1 a5a51234", rsp_valid, rsp_rdata);
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
  endtask

  task automatic test_stall();
    int cyc; logic [31:0] rd0; logic er0;
    wait_states = 0; slv_err = 0;
    @(negedge clk);
    req_addr = 32'h18; req_write = 0; req_valid = 1;
    @(negedge clk);
    req_valid = 0;
    cyc = 0;
    while (!rsp_valid && cyc < 20) begin @(negedge clk); cyc++; end
    rd0 = rsp_rdata; er0 = rsp_err;
    tests++;
    if (rd0 !== 32'hFF) begin fails++; $display("FAIL stall_first_rdata got %h exp ff", rd0); end
    req_valid = 1; req_addr = 32'h04;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hFF || rsp_err !== er0 || req_ready !== 1'b0 || psel !== 1'b0) begin
        fails++; $display("FAIL stall_hold[%0d] got valid=%b rdata=%h err=%b ready=%b psel=%b exp 1 ff 0 0 0",
                          i, rsp_valid, rsp_rdata, rsp_err, req_ready, psel);
      end
    end
    req_valid = 0;
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
  endtask

  task automatic test_reset_mid_access();
    int cyc;
    wait_states = 1000;
    @(negedge clk);
    req_addr = 32'h0C; req_write = 1; req_wdata = 32'h5555_AAAA; req_strb = 4'hA; req_valid = 1;
    @(negedge clk);
    req_valid = 0;
    cyc = 0;
    while (!(psel && penable) && cyc < 20) begin @(negedge clk); cyc++; end
    @(negedge clk);
    rst_n = 0;
    #1;
    tests++;
    if ({psel, penable, pwrite, rsp_valid, rsp_err, pause_ack, req_ready} !== 7'b0 ||
        {paddr, pwdata, pstrb, rsp_rdata} !== '0) begin
      fails++; $display("FAIL mid_access_reset got psel=%b pen=%b pwrite=%b paddr=%h pwdata=%h pstrb=%h exp all 0",
                        psel, penable, pwrite, paddr, pwdata, pstrb);
    end
    @(negedge clk);
    rst_n = 1;
    wait_states = 0;
    @(negedge clk);
  endtask

`ifdef ADAM_APB_INIT_TIMEOUT_EN
  task automatic test_timeout();
    int lat; logic [31:0] rd; logic er; bit ok;
    wait_states = 1000; slv_err = 0;
    run_xfer(32'h18, 1'b0, 32'h0, 4'h0, lat, rd, er, ok);
    tests++;
    if (lat !== 10) begin fails++; $display("FAIL timeout_latency got %0d exp 10", lat); end
    tests++;
    if (er !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL timeout_rsp got err=%b rdata=%h exp 1 0", er, rd); end
    tests++;
    if (psel !== 1'b0 || penable !== 1'b0) begin fails++; $display("FAIL timeout_bus got psel=%b pen=%b exp 0 0", psel, penable); end
    wait_states = 0;
  endtask
`endif

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[6] = 32'h0000_00FF;
    pause_req = 0; req_valid = 0; req_addr = 0; req_write = 0; req_wdata = 0; req_strb = 0;
    rsp_ready = 0;
    test_reset();
    test_write();
    test_read_wait();
    test_slverr();
    test_pause_priority();
    test_pause_drain();
    test_stall();
    test_reset_mid_access();
`ifdef ADAM_APB_INIT_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
